incr_step_controller: RTL and testbench

Sequencing stage wrapped around the N-bit incrementer. It loads a seed value and drives the incrementer's operand inputs (A, B, operand select) from an internal working register, then consumes the incrementer's Y/Cout/Zout outputs one commit per clock. It runs for a programmed number of increments, or until carry-out when the programmed count is 0, and reports the final value, sticky carry, zero flag and step count. Handshake is start/busy/done toward the front-panel controller.

---
 rtl/incr_step_controller.sv | 114 +++++++++++
 tb/tb_incr_step_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/incr_step_controller.sv
// Sequencer around an N-bit incrementer: seeds a working register, feeds it to the
// incrementer each cycle and commits the result until the step count or carry-out ends the run.
module incr_step_controller #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_sel_in,
  input  logic [N-1:0] i_seed,
  input  logic [N-1:0] i_steps,
  output logic [N-1:0] o_op_a,
  output logic [N-1:0] o_op_b,
  output logic         o_op_sel,
  input  logic [N-1:0] i_inc_y,
  input  logic         i_inc_cout,
  input  logic         i_inc_zout,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_carry_flag,
  output logic         o_zero_flag,
  output logic [N:0]   o_step_count
);

  typedef enum logic {ST_IDLE, ST_STEP} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [N-1:0] r_w;
  logic         r_sel;
  logic [N-1:0] r_rem;
  logic         r_run_free;
  logic [N:0]   r_step_count;
  logic         r_carry;
  logic         r_zero;
  logic         r_done;
  logic         w_load;
  logic         w_commit;
  logic         w_term;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    w_term       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_next_state = ST_STEP;
        end
      end
      ST_STEP: begin
        if (i_abort) begin
          w_next_state = ST_IDLE;
        end else begin
          w_commit = 1'b1;
          // Free runs stop on the incrementer's carry; counted runs on the last remaining step.
          w_term   = r_run_free ? i_inc_cout : (r_rem == N'(1));
          if (w_term) w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w          <= '0;
      r_sel        <= 1'b0;
      r_rem        <= '0;
      r_run_free   <= 1'b0;
      r_step_count <= '0;
      r_carry      <= 1'b0;
      r_zero       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_commit & w_term;
      if (w_load) begin
        r_w          <= i_seed;
        r_sel        <= i_sel_in;
        r_rem        <= i_steps;
        r_run_free   <= (i_steps == '0);
        r_step_count <= '0;
        r_carry      <= 1'b0;
        r_zero       <= 1'b0;
      end else if (w_commit) begin
        r_w          <= i_inc_y;
        r_step_count <= r_step_count + (N+1)'(1);
        r_carry      <= r_carry | i_inc_cout;
        r_zero       <= i_inc_zout;
        r_rem        <= r_rem - N'(1);
      end
    end
  end

  assign o_op_sel     = r_sel;
  assign o_op_a       = r_sel ? '0 : r_w;
  assign o_op_b       = r_sel ? r_w : '0;
  assign o_busy       = (r_state == ST_STEP);
  assign o_done       = r_done;
  assign o_result     = r_w;
  assign o_carry_flag = r_carry;
  assign o_zero_flag  = r_zero;
  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_incr_step_controller.sv
// Bench for incr_step_controller: a behavioural incrementer closes the loop and a
// scoreboard queue holds the expected final state of each run until done pulses.
module tb_incr_step_controller;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         sel_in = 1'b0;
  logic [N-1:0] seed = '0;
  logic [N-1:0] steps = '0;
  logic [N-1:0] op_a, op_b;
  logic         op_sel;
  logic [N-1:0] inc_y;
  logic         inc_cout, inc_zout;
  logic         busy, done;
  logic [N-1:0] result;
  logic         carry_flag, zero_flag;
  logic [N:0]   step_count;

  typedef struct {
    int result;
    int count;
    int carry;
    int zero;
    int start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  logic [N-1:0] cur_seed;
  logic         cur_sel;

  incr_step_controller #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_sel_in(sel_in),
    .i_seed(seed), .i_steps(steps), .o_op_a(op_a), .o_op_b(op_b), .o_op_sel(op_sel),
    .i_inc_y(inc_y), .i_inc_cout(inc_cout), .i_inc_zout(inc_zout), .o_busy(busy),
    .o_done(done), .o_result(result), .o_carry_flag(carry_flag), .o_zero_flag(zero_flag),
    .o_step_count(step_count)
  );

  // Incrementer: Cin selects which operand is incremented.
  logic [N-1:0] src;
  assign src = op_sel ? op_b : op_a;
  assign {inc_cout, inc_y} = {1'b0, src} + (N+1)'(1);
  assign inc_zout = (inc_y == '0);

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check_val(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("result", int'(result), e.result);
        check_val("step_count", int'(step_count), e.count);
        check_val("carry_flag", int'(carry_flag), e.carry);
        check_val("zero_flag", int'(zero_flag), e.zero);
        check_val("busy_at_done", int'(busy), 0);
        check_val("done_latency", edge_cnt - e.start_edge, e.count);
      end
    end
  end

  // Called at a negedge; returns one negedge after the start edge.
  task automatic launch(input int s, input int st, input int sl, input bit push,
                        input int er, input int ec, input int ecy, input int ez);
    exp_t e;
    seed = N'(s); steps = N'(st); sel_in = sl[0]; start = 1'b1;
    cur_seed = N'(s); cur_sel = sl[0];
    e.result = er; e.count = ec; e.carry = ecy; e.zero = ez; e.start_edge = edge_cnt + 1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      logic [N-1:0] w;
      w = cur_seed + N'(i);
      check_val("op_sel", int'(op_sel), int'(cur_sel));
      check_val("op_a", int'(op_a), cur_sel ? 0 : int'(w));
      check_val("op_b", int'(op_b), cur_sel ? int'(w) : 0);
      i++;
      @(negedge clk);
    end
    if (!done) check_val("done_timeout", int'(done), 1);
  endtask

  initial begin
    #12;
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_result", int'(result), 0);
    check_val("rst_count", int'(step_count), 0);
    check_val("rst_op_a", int'(op_a), 0);
    check_val("rst_op_sel", int'(op_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_idle_busy", int'(busy), 0);

    @(negedge clk);
    launch(5, 3, 0, 1'b1, 8, 3, 0, 0);
    wait_done(20);

    @(negedge clk);
    launch(14, 3, 1, 1'b1, 1, 3, 1, 0);
    wait_done(20);

    @(negedge clk);
    launch(0, 0, 0, 1'b1, 0, 16, 1, 1);
    wait_done(40);

    @(negedge clk);
    launch(2, 10, 0, 1'b0, 0, 0, 0, 0);
    start = 1'b1; seed = 4'd11; steps = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    check_val("abort_result", int'(result), 4);
    check_val("abort_count", int'(step_count), 2);
    repeat (3) @(negedge clk);
    check_val("abort_idle_busy2", int'(busy), 0);

    launch(6, 2, 0, 1'b1, 8, 2, 0, 0);
    wait_done(20);
    launch(9, 1, 0, 1'b1, 10, 1, 0, 0);
    wait_done(20);

    @(negedge clk);
    launch(3, 8, 1, 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_result", int'(result), 0);
    check_val("midrst_count", int'(step_count), 0);
    check_val("midrst_op_b", int'(op_b), 0);
    check_val("midrst_op_sel", int'(op_sel), 0);
    repeat (2) @(negedge clk);
    check_val("midrst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
